spike_window_readout: RTL and testbench
=======================================

# spike_window_readout

Downstream readout stage of the spiking classifier. It consumes the per-class hidden-layer spike vector, counts spikes per class over a fixed integration window, then runs a sequential argmax. It publishes the winning class index, its count and a tie flag with a one-cycle valid pulse, replacing the free-running per-cycle max of the raw accumulators with a windowed, deterministic decision.

## Interface
- `NUM_CLASSES`, 10, number of spike lanes/classes (≥2)
- `WINDOW`, 64, integration length in cycles (≥1)
- `CNT_W`, 8, per-class counter width; counters saturate at 2^CNT_W−1
- `IDX_W`, $clog2(NUM_CLASSES), winner index width (derived, not overridden)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start_i`  in  1  request a classification window; sampled only in IDLE
- `abort_i`  in  1  cancel current window/scan, return to IDLE, no result
- `spikes_i`  in  NUM_CLASSES  spike vector from hidden layer, bit k = class k
- `busy_o`  out  1  high in INTEGRATE and SCAN
- `valid_o`  out  1  one-cycle pulse: result outputs updated this cycle
- `winner_o`  out  IDX_W  index of class with highest count
- `max_count_o`  out  CNT_W  count of winning class
- `tie_o`  out  1  another class equalled the winning count

## Operation
- FSM states: IDLE, INTEGRATE, SCAN, DONE.
- IDLE: with start_i=1, clear all counters and the window counter, then go to INTEGRATE.
- INTEGRATE: each cycle, every counter k with spikes_i[k]=1 increments, saturating at 2^CNT_W−1. Window counter increments. After WINDOW sampled cycles, go to SCAN.
- SCAN: one class per cycle, index 0..NUM_CLASSES−1.
  - Running best initialised from class 0.
  - Strictly greater count replaces best and clears tie.
  - Equal count sets tie and keeps the lower index.
  - After the last index, go to DONE.
- DONE: register winner/count/tie into outputs, assert valid_o for one cycle, go to IDLE.
- All zero counts: winner_o=0, max_count_o=0, tie_o=1.
- start_i outside IDLE is ignored. It is not queued.
- abort_i in any non-IDLE state returns to IDLE next cycle. Outputs are not updated and valid_o is not pulsed. Abort has priority over start and over state advance.
- Result outputs hold their last values until the next DONE.

## Timing
- Reset values: busy_o=0, valid_o=0, winner_o=0, max_count_o=0, tie_o=0. FSM=IDLE, counters=0.
- start_i=1 in IDLE at cycle t:
  - INTEGRATE samples spikes_i in cycles t+1 … t+WINDOW.
  - SCAN occupies t+WINDOW+1 … t+WINDOW+NUM_CLASSES.
  - valid_o is high in cycle t+WINDOW+NUM_CLASSES+1.
- Total latency is WINDOW+NUM_CLASSES+1 cycles. busy_o is high from t+1 through the last SCAN cycle.
- Back-to-back operation: start_i high during the valid_o cycle is ignored, because DONE is not IDLE. The earliest restart is the cycle after valid_o.
- Reset mid-operation: state, counters and outputs return to reset values on the next edge. No valid_o is issued.
- Spikes arriving outside INTEGRATE are ignored.

## Structure
- Shared package `snn_pkg`: readout FSM state enum, default NUM_CLASSES/WINDOW/CNT_W constants, and a `sat_inc` function for saturating increment, reused by the accumulator stage.
- One sub-module, `spike_counter`: a single CNT_W saturating counter with clear and enable, instantiated NUM_CLASSES times via generate.
- FSM, window counter and sequential argmax live in the top module.

## Test plan
- Single lane, NUM_CLASSES=10, WINDOW=64: start, then spikes_i=10'b0000001000 every cycle.
  - Expect valid_o at start+75, winner_o=3, max_count_o=64, tie_o=0.
- Tie, two lanes: lanes 2 and 7 both spike 20 times, others 5 times.
  - Expect winner_o=2, max_count_o=20, tie_o=1.
- Saturation, WINDOW=300, CNT_W=8: lane 9 spikes every cycle, lane 0 spikes 100 times.
  - Expect winner_o=9, max_count_o=255, tie_o=0.
- No spikes: full window with spikes_i=0.
  - Expect winner_o=0, max_count_o=0, tie_o=1, one valid_o pulse.
- Abort and ignored start:
  - abort_i in INTEGRATE cycle 30: busy_o low next cycle, no valid_o, outputs unchanged from the prior result.
  - start_i held high through busy: exactly one valid_o per accepted start.
- Reset mid-SCAN: rst_n=0 for one cycle during SCAN.
  - Expect all outputs 0, busy_o=0, no valid_o.
  - A following start produces a correct fresh result.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared readout definitions: FSM state encoding, default sizing, saturating increment.
// Pure combinational helpers; no latency and no flow control.
package snn_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_WINDOW      = 64;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INTEGRATE,
    ST_SCAN,
    ST_DONE
  } rd_state_t;

  // Holds at max_val instead of wrapping; callers zero-extend counters up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Per-class saturating spike counter with synchronous clear and enable.
// One-cycle update latency; no backpressure, clear has priority over enable.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= CNT_W'(sat_inc(32'(count), 32'({CNT_W{1'b1}})));
    end
  end

endmodule

// File: rtl/spike_window_readout.sv
// Windowed spike count per class followed by a sequential argmax over the counters.
// Result valid WINDOW+NUM_CLASSES+1 cycles after an accepted start; start is ignored while busy.
module spike_window_readout
  import snn_pkg::*;
#(
  parameter int  NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int  WINDOW      = DEF_WINDOW,
  parameter int  CNT_W       = DEF_CNT_W,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NUM_CLASSES-1:0] spikes_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       winner_o,
  output logic [CNT_W-1:0]       max_count_o,
  output logic                   tie_o
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  rd_state_t        state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] counts [NUM_CLASSES];
  logic             clr;
  logic             win_last;
  logic             scan_last;

  logic [CNT_W-1:0] best_cnt, best_cnt_nxt, cand;
  logic [IDX_W-1:0] best_idx, best_idx_nxt;
  logic             best_tie, best_tie_nxt;

  assign clr       = (state == ST_IDLE) && start_i;
  assign win_last  = (win_cnt == WIN_W'(WINDOW - 1));
  assign scan_last = (scan_idx == IDX_W'(NUM_CLASSES - 1));
  assign busy_o    = (state == ST_INTEGRATE) || (state == ST_SCAN);
  assign valid_o   = (state == ST_DONE);

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    ((state == ST_INTEGRATE) && spikes_i[k]),
      .count (counts[k])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start_i)   state_nxt = ST_INTEGRATE;
      ST_INTEGRATE: if (win_last)  state_nxt = ST_SCAN;
      ST_SCAN:      if (scan_last) state_nxt = ST_DONE;
      ST_DONE:                     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
    if (abort_i && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Lower index wins on equal counts, so only a strictly greater count displaces the best.
  always_comb begin
    cand         = counts[scan_idx];
    best_cnt_nxt = best_cnt;
    best_idx_nxt = best_idx;
    best_tie_nxt = best_tie;
    if (scan_idx == '0) begin
      best_cnt_nxt = cand;
      best_idx_nxt = '0;
      best_tie_nxt = 1'b0;
    end else if (cand > best_cnt) begin
      best_cnt_nxt = cand;
      best_idx_nxt = scan_idx;
      best_tie_nxt = 1'b0;
    end else if (cand == best_cnt) begin
      best_tie_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      win_cnt     <= '0;
      scan_idx    <= '0;
      best_cnt    <= '0;
      best_idx    <= '0;
      best_tie    <= 1'b0;
      winner_o    <= '0;
      max_count_o <= '0;
      tie_o       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (clr) begin
        win_cnt <= '0;
      end else if (state == ST_INTEGRATE) begin
        win_cnt <= win_cnt + WIN_W'(1);
      end

      if ((state == ST_SCAN) && !scan_last) begin
        scan_idx <= scan_idx + IDX_W'(1);
      end else begin
        scan_idx <= '0;
      end

      if (state == ST_SCAN) begin
        best_cnt <= best_cnt_nxt;
        best_idx <= best_idx_nxt;
        best_tie <= best_tie_nxt;
      end

      // Publish on entry to DONE so the result is visible in the valid cycle; an abort suppresses it.
      if ((state == ST_SCAN) && scan_last && !abort_i) begin
        winner_o    <= best_idx_nxt;
        max_count_o <= best_cnt_nxt;
        tie_o       <= best_tie_nxt;
      end
    end
  end

endmodule

// File: tb/tb_spike_window_readout.sv
// Directed + randomized windows on a default instance and a long-window saturation instance.
module tb_spike_window_readout;

  localparam int N  = 10;
  localparam int WA = 64;
  localparam int WB = 300;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a, start_b, abort;
  logic [N-1:0] spikes;
  logic         busy_a, valid_a, tie_a, busy_b, valid_b, tie_b;
  logic [3:0]   winner_a, winner_b;
  logic [7:0]   maxc_a, maxc_b;

  logic         sel;
  logic         o_busy, o_valid, o_tie;
  logic [3:0]   o_winner;
  logic [7:0]   o_maxc;

  int cyc = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_win = 0, last_max = 0, last_tie = 0;

  spike_window_readout dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort), .spikes_i(spikes),
    .busy_o(busy_a), .valid_o(valid_a), .winner_o(winner_a), .max_count_o(maxc_a), .tie_o(tie_a)
  );

  spike_window_readout #(.NUM_CLASSES(N), .WINDOW(WB), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort), .spikes_i(spikes),
    .busy_o(busy_b), .valid_o(valid_b), .winner_o(winner_b), .max_count_o(maxc_b), .tie_o(tie_b)
  );

  assign o_busy   = sel ? busy_b   : busy_a;
  assign o_valid  = sel ? valid_b  : valid_a;
  assign o_tie    = sel ? tie_b    : tie_a;
  assign o_winner = sel ? winner_b : winner_a;
  assign o_maxc   = sel ? maxc_b   : maxc_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_a) vcnt_a <= vcnt_a + 1;
    if (valid_b) vcnt_b <= vcnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // kind: 0 random (dens %), 1 lane 3 only, 2 lanes 2/7 x20 others x5, 3 silent, 4 lane 9 always + lane 0 x100
  function automatic logic [N-1:0] gen(input int kind, input int i, input int dens);
    logic [N-1:0] r;
    r = '0;
    case (kind)
      0: for (int k = 0; k < N; k++) r[k] = ($urandom_range(99) < dens);
      1: r[3] = 1'b1;
      2: for (int k = 0; k < N; k++) r[k] = (k == 2 || k == 7) ? (i < 20) : (i < 5);
      4: begin r[9] = 1'b1; r[0] = (i < 100); end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run(input bit use_sat, input int kind, input int dens, input bit hold,
                     input int abort_at, input int rst_at);
    int  w, t, lat, v0, mx, win, nmax;
    int  cnt [N];
    bit  got;
    logic [N-1:0] sp;
    string tg;
    w  = use_sat ? WB : WA;
    tg = $sformatf("k%0d/d%0d", kind, dens);
    sel = use_sat;
    @(posedge clk); #1;
    set_start(1'b1);
    spikes = N'($urandom);
    t  = cyc;
    v0 = use_sat ? vcnt_b : vcnt_a;
    for (int k = 0; k < N; k++) cnt[k] = 0;

    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
      if (!hold) set_start(1'b0);
      sp = gen(kind, i, dens);
      spikes = sp;
      for (int k = 0; k < N; k++) if (sp[k] && cnt[k] < 255) cnt[k]++;
      if (i == 0) begin
        @(negedge clk);
        chk({tg, " busy_integrate"}, 32'(o_busy), 32'd1);
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        set_start(1'b0);
        spikes = '0;
        @(negedge clk);
        chk("abort_busy", 32'(o_busy), 32'd0);
        repeat (WA + N + 5) @(posedge clk);
        #1;
        chk("abort_no_valid", 32'(vcnt_a - v0), 32'd0);
        chk("abort_winner_held", 32'(o_winner), 32'(last_win));
        chk("abort_max_held", 32'(o_maxc), 32'(last_max));
        chk("abort_tie_held", 32'(o_tie), 32'(last_tie));
        return;
      end
    end

    if (rst_at > 0) begin
      repeat (rst_at) begin
        @(posedge clk); #1;
        spikes = N'($urandom);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_start(1'b0);
      @(negedge clk);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_winner", 32'(o_winner), 32'd0);
      chk("rst_max", 32'(o_maxc), 32'd0);
      chk("rst_tie", 32'(o_tie), 32'd0);
      v0 = vcnt_a;
      repeat (N + 5) @(posedge clk);
      #1;
      chk("rst_no_valid", 32'(vcnt_a - v0), 32'd0);
      last_win = 0; last_max = 0; last_tie = 0;
      return;
    end

    mx = 0;
    for (int k = 0; k < N; k++) if (cnt[k] > mx) mx = cnt[k];
    win = -1; nmax = 0;
    for (int k = 0; k < N; k++) if (cnt[k] == mx) begin
      if (win < 0) win = k;
      nmax++;
    end

    got = 1'b0; lat = 0;
    for (int c = 0; c < N + 10 && !got; c++) begin
      @(posedge clk); #1;
      spikes = N'($urandom);
      @(negedge clk);
      if (o_valid) begin
        got = 1'b1;
        lat = cyc - t;
      end
    end
    chk({tg, " valid_seen"}, 32'(got), 32'd1);
    chk({tg, " latency"}, 32'(lat), 32'(w + N + 1));
    chk({tg, " winner"}, 32'(o_winner), 32'(win));
    chk({tg, " max_count"}, 32'(o_maxc), 32'(mx));
    chk({tg, " tie"}, 32'(o_tie), 32'(nmax > 1));
    @(posedge clk); #1;
    set_start(1'b0);
    spikes = '0;
    @(negedge clk);
    chk({tg, " valid_pulse_end"}, 32'(o_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tg, " one_valid"}, 32'((use_sat ? vcnt_b : vcnt_a) - v0), 32'd1);
    chk({tg, " idle_busy"}, 32'(o_busy), 32'd0);
    if (!use_sat) begin
      last_win = win; last_max = mx; last_tie = (nmax > 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; spikes = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_winner", 32'(winner_a), 32'd0);
    chk("reset_max", 32'(maxc_a), 32'd0);
    chk("reset_tie", 32'(tie_a), 32'd0);
    chk("reset_busy_b", 32'(busy_b), 32'd0);

    run(1'b0, 1, 0, 1'b0, -1, -1);
    run(1'b0, 2, 0, 1'b0, -1, -1);
    run(1'b0, 3, 0, 1'b0, -1, -1);
    run(1'b1, 4, 0, 1'b0, -1, -1);
    run(1'b0, 0, 50, 1'b0, -1, -1);
    run(1'b0, 0, 10, 1'b0, -1, -1);
    run(1'b0, 0, 3, 1'b0, -1, -1);
    run(1'b0, 0, 80, 1'b0, -1, -1);
    run(1'b0, 0, 1, 1'b0, -1, -1);
    run(1'b0, 0, 40, 1'b0, 29, -1);
    run(1'b0, 0, 30, 1'b1, -1, -1);
    run(1'b0, 0, 60, 1'b0, -1, 3);
    run(1'b0, 0, 25, 1'b0, -1, -1);
    run(1'b0, 0, 100, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
